// File: rtl/accum_pkg.sv
// accum_pkg
// Shared definitions for the accumulator-table address sequencer:
//   - output-matrix and systolic-array geometry
//   - derived counts: NSM (sub-matrices down the rows), NSN (across the columns)
//   - derived widths: AW (table address), RW (row-in-sub-matrix),
//     MW (submat_m), NW (submat_n), CW (drain counter)
//   - FSM state encoding for the sequencer
// No ports; import with accum_pkg::*.
package accum_pkg;

  localparam int MAX_OUT_ROWS = 128;
  localparam int MAX_OUT_COLS = 128;
  localparam int SYS_ARR_ROWS = 16;
  localparam int SYS_ARR_COLS = 16;

  // $clog2 returns 0 for a count of 1, which would give a zero-width
  // counter, so every derived width is at least one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  localparam int NSM = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NSN = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int AW  = clog2_min1(MAX_OUT_ROWS * NSN);
  localparam int RW  = clog2_min1(SYS_ARR_ROWS);
  localparam int MW  = clog2_min1(NSM);
  localparam int NW  = clog2_min1(NSN);
  localparam int CW  = clog2_min1(SYS_ARR_COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/accum_addr_sequencer_addr.sv
// accumTableAddr_control
// Pure combinational address arithmetic for one accumulator-table row:
//   addr = submat_n*MAX_OUT_ROWS + submat_m*SYS_ARR_ROWS + sub_row
// Ports:
//   sub_row  in  RW  row inside the current sub-matrix
//   submat_m in  MW  sub-matrix index down the output rows
//   submat_n in  NW  sub-matrix index across the output columns
//   addr     out AW  accumulator-table address
module accumTableAddr_control
  import accum_pkg::*;
(
  input  logic [RW-1:0] sub_row,
  input  logic [MW-1:0] submat_m,
  input  logic [NW-1:0] submat_n,
  output logic [AW-1:0] addr
);

  // Each submat_n block spans a full column of MAX_OUT_ROWS rows; inside it
  // the sub-matrices stack every SYS_ARR_ROWS rows.
  assign addr = AW'(submat_n) * AW'(MAX_OUT_ROWS)
              + AW'(submat_m) * AW'(SYS_ARR_ROWS)
              + AW'(sub_row);

endmodule

// File: rtl/accum_addr_sequencer.sv
// accum_addr_sequencer
// Sequences accumulator-table writes for one divide-and-conquer matrix
// multiply. Counts valid systolic-array output rows, walks the sub-matrix
// order, forms each row's table address and skews address/strobe through a
// per-column pipeline so column k writes k cycles after column 0.
// Ports:
//   clk       in   1                clock, rising edge
//   reset     in   1                synchronous, active-high
//   start     in   1                begin a sequence (only honoured in IDLE)
//   m_last    in   MW               last submat_m index, latched on start
//   n_last    in   NW               last submat_n index, latched on start
//   acc_mode  in   1                1=accumulate, 0=overwrite, latched on start
//   out_valid in   1                systolic array presents a row this cycle
//   wr_en     out  SYS_ARR_COLS     per-column write strobe
//   wr_addr   out  SYS_ARR_COLS*AW  per-column address, column k at [k*AW +: AW]
//   wr_acc    out  SYS_ARR_COLS     per-column accumulate flag
//   busy      out  1                high in RUN and DRAIN
//   done      out  1                one-cycle pulse at sequence end
module accum_addr_sequencer
  import accum_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MW-1:0]              m_last,
  input  logic [NW-1:0]              n_last,
  input  logic                       acc_mode,
  input  logic                       out_valid,
  output logic [SYS_ARR_COLS-1:0]    wr_en,
  output logic [SYS_ARR_COLS*AW-1:0] wr_addr,
  output logic [SYS_ARR_COLS-1:0]    wr_acc,
  output logic                       busy,
  output logic                       done
);

  seq_state_t    state;
  logic [RW-1:0] sub_row;
  logic [MW-1:0] submat_m;
  logic [NW-1:0] submat_n;
  logic [MW-1:0] m_last_q;
  logic [NW-1:0] n_last_q;
  logic          acc_mode_q;
  logic [CW-1:0] drain_cnt;
  logic          capture;
  logic          row_end;
  logic          last_row;
  logic [AW-1:0] row_addr;

  logic          stage_en   [SYS_ARR_COLS];
  logic          stage_acc  [SYS_ARR_COLS];
  logic [AW-1:0] stage_addr [SYS_ARR_COLS];

  // A row is only taken while running; out_valid is ignored elsewhere.
  assign capture  = (state == RUN) && out_valid;
  assign row_end  = (sub_row == RW'(SYS_ARR_ROWS - 1));
  assign last_row = row_end && (submat_m == m_last_q) && (submat_n == n_last_q);

  accumTableAddr_control u_addr (
    .sub_row  (sub_row),
    .submat_m (submat_m),
    .submat_n (submat_n),
    .addr     (row_addr)
  );

  // Sequence control. DRAIN lasts SYS_ARR_COLS cycles so the final row has
  // travelled the whole skew pipeline before done is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      m_last_q   <= '0;
      n_last_q   <= '0;
      acc_mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            m_last_q   <= m_last;
            n_last_q   <= n_last;
            acc_mode_q <= acc_mode;
          end
        end
        RUN: begin
          if (capture && last_row) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == CW'(SYS_ARR_COLS - 1)) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Row walk: sub_row fastest, then submat_m, then submat_n. The final row
  // leaves the counters alone; the next start clears them anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_row  <= '0;
      submat_m <= '0;
      submat_n <= '0;
    end else if ((state == IDLE) && start) begin
      sub_row  <= '0;
      submat_m <= '0;
      submat_n <= '0;
    end else if (capture && !last_row) begin
      if (row_end) begin
        sub_row <= '0;
        if (submat_m == m_last_q) begin
          submat_m <= '0;
          submat_n <= submat_n + 1'b1;
        end else begin
          submat_m <= submat_m + 1'b1;
        end
      end else begin
        sub_row <= sub_row + 1'b1;
      end
    end
  end

  // Skew pipeline: stage 0 registers the captured row, stage k+1 follows
  // stage k one cycle later. An empty stage keeps its last address and flag.
  genvar k;
  for (k = 0; k < SYS_ARR_COLS; k++) begin : g_skew
    if (k == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_en[0]   <= 1'b0;
          stage_acc[0]  <= 1'b0;
          stage_addr[0] <= '0;
        end else begin
          stage_en[0] <= capture;
          if (capture) begin
            stage_acc[0]  <= acc_mode_q;
            stage_addr[0] <= row_addr;
          end
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_en[k]   <= 1'b0;
          stage_acc[k]  <= 1'b0;
          stage_addr[k] <= '0;
        end else begin
          stage_en[k] <= stage_en[k-1];
          if (stage_en[k-1]) begin
            stage_acc[k]  <= stage_acc[k-1];
            stage_addr[k] <= stage_addr[k-1];
          end
        end
      end
    end
  end

  // Pack the per-stage registers onto the flat output buses.
  always_comb begin
    wr_en   = '0;
    wr_acc  = '0;
    wr_addr = '0;
    for (int i = 0; i < SYS_ARR_COLS; i++) begin
      wr_en[i]            = stage_en[i];
      wr_acc[i]           = stage_acc[i];
      wr_addr[i*AW +: AW] = stage_addr[i];
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_accum_addr_sequencer.sv
// tb_accum_addr_sequencer
// Drives directed and random sequences into accum_addr_sequencer and checks
// every cycle against a row-list model of the sequence, plus literal values
// for a few hand-worked scenarios.
`timescale 1ns/1ps
module tb_accum_addr_sequencer;
  import accum_pkg::*;

  localparam int COLS = SYS_ARR_COLS;

  logic                 clk = 1'b0;
  logic                 reset, start, acc_mode, out_valid;
  logic [MW-1:0]        m_last;
  logic [NW-1:0]        n_last;
  logic [COLS-1:0]      wr_en, wr_acc;
  logic [COLS*AW-1:0]   wr_addr;
  logic                 busy, done;

  accum_addr_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m_last    (m_last),
    .n_last    (n_last),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_acc    (wr_acc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: pending row addresses of the current run, cycle of the last
  // capture, and a ring of expected column writes indexed by cycle.
  bit              mdl_running = 1'b0;
  int              mdl_last_cap = -1;
  int              mdl_rows[$];
  bit              mdl_acc = 1'b0;
  bit [COLS-1:0]   exp_en   [32];
  int              exp_addr [32][COLS];
  bit              exp_acc  [32][COLS];

  // Recorded DUT outputs per cycle for the literal checks.
  int h_en[int], h_a0[int], h_a15[int], h_busy[int], h_done[int];
  int h_acc0[int], h_acc15[int];
  int wr_count[COLS];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic bit mdlIdle(input int c);
    return !mdl_running && (mdl_last_cap < 0 || c >= mdl_last_cap + COLS + 2);
  endfunction

  // Model update for the cycle ending at this edge.
  always @(posedge clk) begin
    if (reset) begin
      mdl_running  = 1'b0;
      mdl_last_cap = -1;
      mdl_rows.delete();
      for (int i = 0; i < 32; i++) exp_en[i] = '0;
    end else if (mdlIdle(cyc)) begin
      if (start) begin
        mdl_rows.delete();
        for (int n = 0; n <= int'(n_last); n++)
          for (int m = 0; m <= int'(m_last); m++)
            for (int r = 0; r < SYS_ARR_ROWS; r++)
              mdl_rows.push_back(n*MAX_OUT_ROWS + m*SYS_ARR_ROWS + r);
        mdl_acc      = acc_mode;
        mdl_running  = 1'b1;
        mdl_last_cap = -1;
      end
    end else if (mdl_running && out_valid) begin
      int a;
      int slot;
      a = mdl_rows.pop_front();
      for (int k = 0; k < COLS; k++) begin
        slot = (cyc + 1 + k) % 32;
        exp_en[slot][k]   = 1'b1;
        exp_addr[slot][k] = a;
        exp_acc[slot][k]  = mdl_acc;
      end
      if (mdl_rows.size() == 0) begin
        mdl_running  = 1'b0;
        mdl_last_cap = cyc;
      end
    end
    cyc = cyc + 1;
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    int s;
    int exp_busy;
    int exp_done;
    if (cyc > 0) begin
      s = cyc % 32;
      exp_busy = (mdl_running || (mdl_last_cap >= 0 && cyc <= mdl_last_cap + COLS)) ? 1 : 0;
      exp_done = (mdl_last_cap >= 0 && cyc == mdl_last_cap + COLS + 1) ? 1 : 0;
      checkOutput("wr_en", int'(wr_en), int'(exp_en[s]));
      for (int k = 0; k < COLS; k++) begin
        if (exp_en[s][k]) begin
          checkOutput($sformatf("wr_addr[%0d]", k), int'(wr_addr[k*AW +: AW]), exp_addr[s][k]);
          checkOutput($sformatf("wr_acc[%0d]", k), int'(wr_acc[k]), int'(exp_acc[s][k]));
        end
        if (wr_en[k]) wr_count[k]++;
      end
      checkOutput("busy", int'(busy), exp_busy);
      checkOutput("done", int'(done), exp_done);
      exp_en[s] = '0;
      h_en[cyc]    = int'(wr_en);
      h_a0[cyc]    = int'(wr_addr[0 +: AW]);
      h_a15[cyc]   = int'(wr_addr[(COLS-1)*AW +: AW]);
      h_busy[cyc]  = int'(busy);
      h_done[cyc]  = int'(done);
      h_acc0[cyc]  = int'(wr_acc[0]);
      h_acc15[cyc] = int'(wr_acc[COLS-1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit ov,
                               input int ml, input int nl, input bit am);
    reset     = rst;
    start     = st;
    out_valid = ov;
    m_last    = MW'(ml);
    n_last    = NW'(nl);
    acc_mode  = am;
    tick();
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((busy || done) && guard < 400) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      guard++;
    end
    if (busy || done) checkOutput("idle_timeout", 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int t0;
    int r;
    int rows;
    foreach (wr_count[i]) wr_count[i] = 0;
    reset = 1'b1; start = 1'b0; out_valid = 1'b0;
    m_last = '0; n_last = '0; acc_mode = 1'b0;
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reset_wr_en", h_en[cyc-1], 0);
    checkOutput("reset_wr_addr0", h_a0[cyc-1], 0);
    checkOutput("reset_busy", h_busy[cyc-1], 0);

    // Single sub-matrix, back-to-back rows.
    $display("[TB] single sub-matrix run");
    applyStimulus(0, 1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    waitIdle();
    checkOutput("t1_col0_first_en", h_en[t0+1] & 1, 1);
    checkOutput("t1_col0_first", h_a0[t0+1], 0);
    checkOutput("t1_col0_last", h_a0[t0+16], 15);
    checkOutput("t1_col15_first", h_a15[t0+16], 0);
    checkOutput("t1_col15_last", h_a15[t0+31], 15);
    checkOutput("t1_last_cycle_en", h_en[t0+31], 32'h8000);
    checkOutput("t1_done", h_done[t0+32], 1);
    checkOutput("t1_done_early", h_done[t0+31], 0);
    checkOutput("t1_busy_after", h_busy[t0+33], 0);

    // Four sub-matrices, continuous rows, accumulate mode.
    $display("[TB] 2x2 sub-matrix run");
    foreach (wr_count[i]) wr_count[i] = 0;
    applyStimulus(0, 1, 0, 1, 1, 1);
    t0 = cyc;
    for (int i = 0; i < 64; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    waitIdle();
    checkOutput("t2_col0_row16", h_a0[t0+17], 16);
    checkOutput("t2_col0_row32", h_a0[t0+33], 128);
    checkOutput("t2_col0_row63", h_a0[t0+64], 159);
    checkOutput("t2_col0_count", wr_count[0], 64);
    checkOutput("t2_col15_count", wr_count[COLS-1], 64);
    checkOutput("t2_done", h_done[t0+63+17], 1);
    checkOutput("t2_col15_tail_acc", h_acc15[t0+63+16], 1);

    // Gapped rows.
    $display("[TB] gapped run");
    applyStimulus(0, 1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, (i % 2) == 0, 0, 0, 0);
    waitIdle();
    checkOutput("t3_col0_a", h_a0[t0+1], 0);
    checkOutput("t3_col0_gap_en", h_en[t0+2] & 1, 0);
    checkOutput("t3_col0_gap_hold", h_a0[t0+2], 0);
    checkOutput("t3_col0_b", h_a0[t0+3], 1);
    checkOutput("t3_skew_pattern", h_en[t0+16], 32'hAAAA);
    checkOutput("t3_col15_b", h_a15[t0+18], 1);

    // out_valid while idle, then start while busy with different limits.
    $display("[TB] ignored start / out_valid");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 3, 3, 1);
    checkOutput("t4_idle_busy", h_busy[cyc-1], 0);
    checkOutput("t4_idle_en", h_en[cyc-1], 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 16; i++) applyStimulus(0, (i == 4), 1, 3, 3, 1);
    waitIdle();
    checkOutput("t4_done_unchanged", h_done[t0+32], 1);

    // Reset in the middle of a run, then a clean run.
    $display("[TB] reset mid-run");
    applyStimulus(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    r = cyc;
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_flush_en", h_en[r+1], 0);
    checkOutput("t5_flush_busy", h_busy[r+1], 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    t0 = cyc;
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    waitIdle();
    checkOutput("t5_restart_done", h_done[t0+32], 1);
    checkOutput("t5_restart_col0", h_a0[t0+16], 15);

    // Accumulate run followed by an overwrite run.
    $display("[TB] acc_mode switch");
    applyStimulus(0, 1, 0, 0, 0, 1);
    t0 = cyc;
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    waitIdle();
    checkOutput("t6_run1_tail_acc", h_acc15[t0+31], 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 1);
    waitIdle();
    checkOutput("t6_run2_acc", h_acc0[t0+1], 0);

    // Random sequences: random limits, gaps, stray starts and rare resets.
    $display("[TB] random runs");
    for (int it = 0; it < 40; it++) begin
      int c;
      applyStimulus(0, 1, 0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      c = 0;
      while (c < 2000) begin
        applyStimulus(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        c++;
        if (!busy && !done && c > 2) break;
      end
      if (c >= 2000) checkOutput("random_timeout", 1, 0);
      waitIdle();
    end

    rows = n_vec;
    $display("== %0d vectors applied, %0d miscompares ==", rows, n_fail);
    $finish;
  end

endmodule
